// File: rtl/store_trace_fifo.sv
// Capture buffer for processor data-memory stores. Each store strobe pushes
// the (address, data) pair into a show-ahead FIFO that a host drains over valid/ready.
module store_trace_fifo #(
  parameter int N     = 64,
  parameter int DEPTH = 8,
  parameter int AW    = $clog2(DEPTH)
) (
  input  logic          CLOCK_50,
  input  logic          reset,
  input  logic          DM_writeEnable,
  input  logic [N-1:0]  DM_addr,
  input  logic [N-1:0]  DM_writeData,
  input  logic          out_ready,
  output logic          out_valid,
  output logic [N-1:0]  out_addr,
  output logic [N-1:0]  out_data,
  output logic [AW:0]   count,
  output logic          overflow,
  output logic [7:0]    drop_count,
  input  logic          clr_overflow
);

  localparam logic [AW:0]   FULL_CNT = (AW+1)'(DEPTH);
  localparam logic [AW:0]   CNT_ONE  = (AW+1)'(1);
  localparam logic [AW-1:0] PTR_ONE  = AW'(1);

  logic [2*N-1:0] mem_q [DEPTH];
  logic [AW-1:0]  wp_q, wp_d;
  logic [AW-1:0]  rp_q, rp_d;
  logic [AW:0]    count_q, count_d;
  logic           overflow_q, overflow_d;
  logic [7:0]     drop_q, drop_d;

  logic push, pop, full, accept, drop;

  // Handshake: the head transfers on any cycle where out_valid and out_ready
  // are both high; out_ready while empty has no effect. The producer side has
  // no back-pressure, so a store arriving while full is dropped and counted.
  always_comb begin
    push       = DM_writeEnable;
    pop        = (count_q != '0) & out_ready;
    full       = (count_q == FULL_CNT);
    accept     = push & (~full | pop);
    drop       = push & full & ~pop;
    wp_d       = accept ? wp_q + PTR_ONE : wp_q;
    rp_d       = pop ? rp_q + PTR_ONE : rp_q;
    count_d    = count_q;
    overflow_d = overflow_q;
    drop_d     = drop_q;
    case ({accept, pop})
      2'b10:   count_d = count_q + CNT_ONE;
      2'b01:   count_d = count_q - CNT_ONE;
      default: count_d = count_q;
    endcase
    // Clearing wins over a same-cycle drop, which is then not recorded.
    if (clr_overflow) begin
      overflow_d = 1'b0;
      drop_d     = 8'd0;
    end else if (drop) begin
      overflow_d = 1'b1;
      drop_d     = (drop_q == 8'hFF) ? drop_q : drop_q + 8'd1;
    end
  end

  always_ff @(posedge CLOCK_50) begin
    if (reset) begin
      wp_q       <= '0;
      rp_q       <= '0;
      count_q    <= '0;
      overflow_q <= 1'b0;
      drop_q     <= 8'd0;
    end else begin
      wp_q       <= wp_d;
      rp_q       <= rp_d;
      count_q    <= count_d;
      overflow_q <= overflow_d;
      drop_q     <= drop_d;
    end
  end

  always_ff @(posedge CLOCK_50) begin
    if (!reset && accept) begin
      mem_q[wp_q] <= {DM_addr, DM_writeData};
    end
  end

  assign out_valid  = (count_q != '0);
  assign out_addr   = mem_q[rp_q][2*N-1:N];
  assign out_data   = mem_q[rp_q][N-1:0];
  assign count      = count_q;
  assign overflow   = overflow_q;
  assign drop_count = drop_q;

endmodule

// File: doc/store_trace_fifo.md
# store_trace_fifo

Store-transaction capture buffer that sits directly downstream of the processor's data-memory write port. Every cycle in which the core asserts `DM_writeEnable`, the block pushes the pair (`DM_addr`, `DM_writeData`) into a small FIFO. A bench or debug host drains the FIFO over a valid/ready interface. The core is never stalled: overflow drops entries, sets a sticky flag and counts the losses.

## Interface

Parameters
- `N`, 64: address and data width; matches the processor datapath width.
- `DEPTH`, 8: FIFO entries; must be a power of two and ≥ 2.
- `AW`, `$clog2(DEPTH)`: pointer width (derived; do not override).

Ports
- `CLOCK_50`  in  1  single clock; all state changes on the rising edge.
- `reset`  in  1  synchronous, active-high reset.
- `DM_writeEnable`  in  1  store strobe from the processor.
- `DM_addr`  in  N  store byte address, captured unmodified.
- `DM_writeData`  in  N  store data, captured unmodified.
- `out_ready`  in  1  consumer accepts the head entry this cycle.
- `out_valid`  out  1  head entry present; equals `count != 0`.
- `out_addr`  out  N  address of the head entry.
- `out_data`  out  N  data of the head entry.
- `count`  out  AW+1  number of stored entries, 0..DEPTH.
- `overflow`  out  1  sticky flag: at least one store was dropped.
- `drop_count`  out  8  number of dropped stores, saturating at 255.
- `clr_overflow`  in  1  clears `overflow` and `drop_count`.

## Operation

- Storage: a DEPTH×(2N) register array, a write pointer `wp`, a read pointer `rp` (each AW bits, wrapping naturally at DEPTH) and an explicit `count` register.
- push = `DM_writeEnable`; pop = `out_valid & out_ready`.
- Push accepted when `count < DEPTH`, or when `count == DEPTH` and pop is asserted in the same cycle. An accepted push writes `mem[wp]` and increments `wp`.
- Pop increments `rp`. The head entry is presented show-ahead: `out_addr`/`out_data` = `mem[rp]`, read combinationally from the array. It is stable while `out_valid & ~out_ready`.
- `count` update:
  - +1 for an accepted push without pop.
  - −1 for a pop without push.
  - Unchanged for push+pop, or for neither.
- Dropped push: push while `count == DEPTH` and no pop.
  - Array and pointers unchanged.
  - `overflow` ← 1.
  - `drop_count` ← `drop_count + 1`, held at 255 once reached.
- `clr_overflow` clears `overflow` and `drop_count` to 0. It has priority over a drop in the same cycle; that drop is not recorded.
- `out_ready` while empty: ignored; no pointer movement.
- Pointer wrap: `wp` and `rp` roll DEPTH−1 → 0. Full and empty are distinguished by `count`, never by pointer equality.
- Entries are never reordered or merged. Back-to-back stores on consecutive cycles each occupy one entry.

## Timing

- Reset (synchronous, `reset` high at a rising edge):
  - `wp`, `rp`, `count` = 0; `out_valid` = 0; `overflow` = 0; `drop_count` = 0.
  - Array contents are don't-care; `out_addr`/`out_data` are don't-care while `out_valid` = 0.
- Reset mid-operation discards all entries. Stores presented in the reset cycle are not captured.
- Latency: a store captured at edge k is visible on `out_*` with `out_valid` = 1 from edge k onward, i.e. in the cycle after the store cycle. There is no combinational path from `DM_*` to `out_*`.
- Throughput: one push and one pop per cycle, sustained indefinitely with no loss.
- `count`, `overflow`, `drop_count` are registered and update at the same edge as the event that changes them.

## Test plan

- Reset, then idle 3 cycles → `out_valid` = 0, `count` = 0, `overflow` = 0, `drop_count` = 0.
- Three stores (0x10, 0xA), (0x18, 0xB), (0x20, 0xC) with `out_ready` = 0, then `out_ready` = 1 → `count` reaches 3; the outputs pop in order 0x10/0xA, 0x18/0xB, 0x20/0xC; `out_valid` drops after the third pop.
- DEPTH+3 = 11 consecutive stores with `out_ready` = 0 → `count` = 8, `overflow` = 1, `drop_count` = 3; draining returns the first 8 stores only.
- Fill to 8, then a store with `out_ready` = 1 in the same cycle → `count` stays 8, `overflow` stays 0, and the new entry emerges last.
- 20 cycles with a store every cycle and `out_ready` = 1 (pointers wrap twice) → `count` stays ≤ 1 and all 20 pairs emerge in order.
- With `overflow` = 1 and `drop_count` = 3, pulse `clr_overflow` → both 0 next cycle. Then assert `reset` while `count` = 5 → `count` = 0 and `out_valid` = 0 after the edge.
